// File: rtl/store_align.sv
// store_align: turns a BYTE/HALF/WORD store request into one or two
// word-aligned, lane-positioned write beats on a 32-bit memory bus, then
// pulses done (or fault for rejected requests) for exactly one cycle.
// Optional feature macro: STORE_MISALIGN_SPLIT_EN. When defined, misaligned
// stores are carried out, split into two beats when they cross a word.
// When undefined, misaligned HALF/WORD stores are rejected with fault.
module store_align #(
    parameter int WORD_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WORD_SIZE-1:0]   req_addr,
    input  logic [WORD_SIZE-1:0]   req_data,
    input  logic [2:0]             req_sel,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [WORD_SIZE-1:0]   bus_addr,
    output logic [WORD_SIZE-1:0]   bus_wdata,
    output logic [WORD_SIZE/8-1:0] bus_strb,
    output logic                   done,
    output logic                   fault
);

    localparam int SW = WORD_SIZE / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [WORD_SIZE-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_data;
    logic [2:0]             r_sel;
    logic                   r_fault;

    logic                   w_accept;
    logic                   w_req_illegal;
    logic [1:0]             w_off;
    logic [WORD_SIZE-1:0]   w_data_sized;
    logic [2*SW-1:0]        w_size_mask;
    logic [2*SW-1:0]        w_mask;
    logic [2*WORD_SIZE-1:0] w_shifted;
    logic [WORD_SIZE-1:0]   w_base;
    logic                   w_has_high;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Classify the incoming request: unknown sizes are always rejected,
    // natural-alignment violations only when splitting is not built in.
    always_comb begin
        w_req_illegal = (req_sel > 3'd2);
`ifdef STORE_MISALIGN_SPLIT_EN
        w_req_illegal = w_req_illegal;
`else
        if ((req_sel == 3'd1) && req_addr[0])
            w_req_illegal = 1'b1;
        if ((req_sel == 3'd2) && (req_addr[1:0] != 2'b00))
            w_req_illegal = 1'b1;
`endif
    end

    // Capture the request on accept; the beats are derived from these copies
    // so bus outputs stay stable while the memory stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_data  <= req_data;
            r_sel   <= req_sel;
            r_fault <= w_req_illegal;
        end
    end

    // Lane math: trim data to its size, then shift data and mask by the
    // byte offset into a two-word window (low beat / high beat).
    always_comb begin
        w_off = r_addr[1:0];
        case (r_sel)
            3'd0: begin
                w_data_sized = WORD_SIZE'(r_data[7:0]);
                w_size_mask  = (2*SW)'(4'b0001);
            end
            3'd1: begin
                w_data_sized = WORD_SIZE'(r_data[15:0]);
                w_size_mask  = (2*SW)'(4'b0011);
            end
            3'd2: begin
                w_data_sized = r_data;
                w_size_mask  = (2*SW)'(4'b1111);
            end
            default: begin
                w_data_sized = '0;
                w_size_mask  = '0;
            end
        endcase
        w_mask     = w_size_mask << w_off;
        w_shifted  = {{WORD_SIZE{1'b0}}, w_data_sized} << {w_off, 3'b000};
        w_base     = {r_addr[WORD_SIZE-1:2], 2'b00};
        w_has_high = |w_mask[2*SW-1:SW];
    end

    // State register; reset abandons any store in flight without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid)
                    w_state_next = w_req_illegal ? S_RESP : S_BEAT0;
            end
            S_BEAT0: begin
                if (bus_ready)
                    w_state_next = w_has_high ? S_BEAT1 : S_RESP;
            end
            S_BEAT1: begin
                if (bus_ready)
                    w_state_next = S_RESP;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; everything is zero outside the beats.
    always_comb begin
        req_ready = 1'b0;
        bus_valid = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_strb  = '0;
        done      = 1'b0;
        fault     = 1'b0;
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_BEAT0: begin
                bus_valid = 1'b1;
                bus_addr  = w_base;
                bus_wdata = w_shifted[WORD_SIZE-1:0];
                bus_strb  = w_mask[SW-1:0];
            end
            S_BEAT1: begin
                bus_valid = 1'b1;
                bus_addr  = w_base + WORD_SIZE'(4);
                bus_wdata = w_shifted[2*WORD_SIZE-1:WORD_SIZE];
                bus_strb  = w_mask[2*SW-1:SW];
            end
            default: begin
                done  = ~r_fault;
                fault = r_fault;
            end
        endcase
    end

endmodule

// File: tb/tb_store_align.sv
// Scoreboard bench for store_align: stimulus pushes expected beats and
// completions into a queue, a negedge monitor pops and compares them.
module tb_store_align;

    localparam int K_BEAT  = 0;
    localparam int K_DONE  = 1;
    localparam int K_FAULT = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [2:0]  req_sel = '0;
    logic        bus_valid;
    logic        bus_ready = 1'b1;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        done;
    logic        fault;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    store_align #(.WORD_SIZE(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_sel   (req_sel),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_strb  (bus_strb),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        exp_t e;
        e.kind = K_BEAT; e.addr = a; e.wdata = w; e.strb = s;
        sb_q.push_back(e);
    endtask

    task automatic push_resp(input int k);
        exp_t e;
        e.kind = k; e.addr = '0; e.wdata = '0; e.strb = '0;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_data = d; req_sel = s;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_sel = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL idle_timeout: req_ready=%0b required 1", req_ready);
        end
    endtask

    // Monitor: compares every presented beat / completion with the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_valid) begin
                checks++;
                if (sb_q.size() == 0 || sb_q[0].kind != K_BEAT) begin
                    errors++;
                    $display("FAIL unexpected_beat: got addr=0x%08h wdata=0x%08h strb=%04b, required no beat",
                             bus_addr, bus_wdata, bus_strb);
                end else begin
                    mon_e = sb_q[0];
                    if (bus_addr !== mon_e.addr || bus_wdata !== mon_e.wdata || bus_strb !== mon_e.strb) begin
                        errors++;
                        $display("FAIL beat: got addr=0x%08h wdata=0x%08h strb=%04b required addr=0x%08h wdata=0x%08h strb=%04b",
                                 bus_addr, bus_wdata, bus_strb, mon_e.addr, mon_e.wdata, mon_e.strb);
                    end
                    if (bus_ready) begin
                        void'(sb_q.pop_front());
                        $display("beat addr=0x%08h wdata=0x%08h strb=%04b", bus_addr, bus_wdata, bus_strb);
                    end
                end
            end else begin
                checks++;
                if (bus_strb !== 4'b0000) begin
                    errors++;
                    $display("FAIL idle_strb: got %04b required 0000", bus_strb);
                end
            end
            if (done || fault) begin
                checks++;
                if (done && fault) begin
                    errors++;
                    $display("FAIL done_fault_both: got done=1 fault=1 required exclusive");
                end else if (sb_q.size() == 0 || sb_q[0].kind == K_BEAT) begin
                    errors++;
                    $display("FAIL unexpected_resp: got done=%0b fault=%0b required none", done, fault);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ((mon_e.kind == K_DONE) !== done) begin
                        errors++;
                        $display("FAIL resp_kind: got done=%0b fault=%0b required %s",
                                 done, fault, (mon_e.kind == K_DONE) ? "done" : "fault");
                    end else begin
                        $display("resp %s", done ? "done" : "fault");
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_addr",  bus_addr,       32'd0);
        chk("rst_bus_wdata", bus_wdata,      32'd0);
        chk("rst_bus_strb",  32'(bus_strb),  32'd0);
        chk("rst_done_fault", {30'd0, done, fault}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // SB 0x103: single beat, latency checks
        push_beat(32'h0000_0100, 32'hAB00_0000, 4'b1000);
        push_resp(K_DONE);
        issue(32'h0000_0103, 32'h0000_00AB, 3'd0);
        chk("sb_valid_t1", 32'(bus_valid), 32'd1);
        @(posedge clk); #1;
        chk("sb_done_h1", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("sb_ready_h2", 32'(req_ready), 32'd1);
        chk("sb_done_once", 32'(done), 32'd0);

        // SW 0x200 with 3 stall cycles
        bus_ready = 1'b0;
        push_beat(32'h0000_0200, 32'hDEAD_BEEF, 4'b1111);
        push_resp(K_DONE);
        issue(32'h0000_0200, 32'hDEAD_BEEF, 3'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("sw_stall_valid", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1;
        wait_idle();

        // SW 0x102: misaligned word
`ifdef STORE_MISALIGN_SPLIT_EN
        push_beat(32'h0000_0100, 32'h3344_0000, 4'b1100);
        push_beat(32'h0000_0104, 32'h0000_1122, 4'b0011);
        push_resp(K_DONE);
`else
        push_resp(K_FAULT);
`endif
        issue(32'h0000_0102, 32'h1122_3344, 3'd2);
        wait_idle();

        // SH 0xFFFFFFFF: address wrap
`ifdef STORE_MISALIGN_SPLIT_EN
        push_beat(32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
        push_beat(32'h0000_0000, 32'h0000_00BE, 4'b0001);
        push_resp(K_DONE);
`else
        push_resp(K_FAULT);
`endif
        issue(32'hFFFF_FFFF, 32'h0000_BEEF, 3'd1);
        wait_idle();

        // SH aligned, upper data bits must not reach the bus
        push_beat(32'h0000_0300, 32'hCAFE_0000, 4'b1100);
        push_resp(K_DONE);
        issue(32'h0000_0302, 32'h1234_CAFE, 3'd1);
        wait_idle();

        // SB at lane 0
        push_beat(32'h0000_0000, 32'h0000_005A, 4'b0001);
        push_resp(K_DONE);
        issue(32'h0000_0000, 32'hFFFF_FF5A, 3'd0);
        wait_idle();

        // Illegal sel=5
        push_resp(K_FAULT);
        issue(32'h0000_0040, 32'h0000_0001, 3'd5);
        chk("sel5_fault_t1", 32'(fault), 32'd1);
        chk("sel5_no_valid", 32'(bus_valid), 32'd0);
        @(posedge clk); #1;
        chk("sel5_ready_t2", 32'(req_ready), 32'd1);

        // Illegal sel=3
        push_resp(K_FAULT);
        issue(32'h0000_0000, 32'h0000_0001, 3'd3);
        wait_idle();

        // Reset during a beat abandons the store
`ifdef STORE_MISALIGN_SPLIT_EN
        push_beat(32'h0000_0400, 32'h0203_0400, 4'b1110);
        push_beat(32'h0000_0404, 32'h0000_0001, 4'b0001);
        issue(32'h0000_0401, 32'h0102_0304, 3'd2);
        bus_ready = 1'b0;
        @(posedge clk); #1;
`else
        bus_ready = 1'b0;
        push_beat(32'h0000_0400, 32'hA5A5_A5A5, 4'b1111);
        issue(32'h0000_0400, 32'hA5A5_A5A5, 3'd2);
        @(posedge clk); #1;
`endif
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_no_done", {30'd0, done, fault}, 32'd0);
        sb_q.delete();
        bus_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Store after reset completes normally
        push_beat(32'h0000_0500, 32'h0077_0000, 4'b0100);
        push_resp(K_DONE);
        issue(32'h0000_0502, 32'h0000_0077, 3'd0);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
